if_stage: RTL and testbench

- Two-stage instruction fetch front end: IF1 (PC register, issues synchronous I-SRAM read) and IF2 (receives SRAM data).
- Produces if22id_bus = {pc, inst}, consumed directly by the ID stage register.
- Handles pipeline stall, branch redirect from EX, and holding fetched data across stalls.

---
 rtl/if_stage_pkg.sv | 30 +++
 rtl/if_stage_inst_hold_buf.sv | 57 +++++
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Definitions shared by the instruction-fetch front end: bus widths, the reset
// fetch address, stall-vector bit positions, the bubble encoding and a helper
// that word-aligns a byte address.
// -----------------------------------------------------------------------------
package if_stage_pkg;

   // Stall-vector width and IF2->ID bus width.
   localparam int unsigned STALL_BUS_WD  = 6;
   localparam int unsigned IF22ID_BUS_WD = 64;

   // First fetch address after reset.
   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

   // Bit positions inside the stall vector. The vector is monotone, so a
   // stall of a later stage always implies a stall of every earlier one.
   localparam int unsigned STALL_IF1 = 0;
   localparam int unsigned STALL_IF2 = 1;
   localparam int unsigned STALL_ID  = 2;

   // A bubble on the IF2->ID bus is all zeros.
   localparam logic [IF22ID_BUS_WD-1:0] IF22ID_BUBBLE = '0;

   // Instructions are word aligned; redirect targets drop their low two bits.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_stage_inst_hold_buf.sv
// -----------------------------------------------------------------------------
// if_stage_inst_hold_buf
// Keeps the instruction sitting in IF2 alive while IF2 is frozen. The SRAM
// returns data only in the cycle after an enabled read, so on the first stalled
// cycle the data is captured here and presented until IF2 advances again.
//
// Ports:
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   stall_i      in   IF2 frozen this cycle
//   if2_valid_i  in   IF2 holds a real instruction
//   br_e_i       in   redirect from EX; discards any held data
//   rdata_i      in   SRAM read data
//   inst_o       out  instruction presented by IF2
// -----------------------------------------------------------------------------
module if_stage_inst_hold_buf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        if2_valid_i,
   input  logic        br_e_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] inst_o
);

   logic [31:0] hold_inst_q, hold_inst_d;
   logic        hold_valid_q, hold_valid_d;
   logic        capture;

   // Capture only once per stall: the first cycle's rdata is the genuine
   // instruction, later cycles see whatever the idle SRAM drives.
   assign capture = stall_i & if2_valid_i & ~hold_valid_q & ~br_e_i;

   always_comb begin
      hold_inst_d  = hold_inst_q;
      hold_valid_d = hold_valid_q;
      if (br_e_i || !stall_i) begin
         hold_valid_d = 1'b0;
      end else if (capture) begin
         hold_inst_d  = rdata_i;
         hold_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_inst_q  <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         hold_inst_q  <= hold_inst_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   assign inst_o = hold_valid_q ? hold_inst_q : rdata_i;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Two-stage instruction fetch. IF1 owns the PC and issues a synchronous I-SRAM
// read; IF2 receives the data one cycle later and drives {pc, inst} to the ID
// stage register. Handles stage freezes, EX redirects and keeps the IF2
// instruction intact across stalls.
//
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous active-low reset
//   stall       in   freeze vector, bit0 = IF1, bit1 = IF2, bit2 = ID
//   br_e        in   branch/jump taken in EX
//   br_addr     in   redirect target (low two bits ignored)
//   imem_en     out  SRAM read enable
//   imem_addr   out  SRAM byte address
//   imem_rdata  in   SRAM data, valid the cycle after an enabled read
//   if22id_bus  out  {pc, inst}; all zero is a bubble
// -----------------------------------------------------------------------------
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int unsigned STALL_WD  = STALL_BUS_WD,
   parameter int unsigned IF22ID_WD = IF22ID_BUS_WD
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [STALL_WD-1:0]  stall,
   input  logic                 br_e,
   input  logic [31:0]          br_addr,
   output logic                 imem_en,
   output logic [31:0]          imem_addr,
   input  logic [31:0]          imem_rdata,
   output logic [IF22ID_WD-1:0] if22id_bus
);

   logic [31:0] if1_pc_q, if1_pc_d;
   logic        if1_valid_q, if1_valid_d;
   logic [31:0] if2_pc_q, if2_pc_d;
   logic        if2_valid_q, if2_valid_d;
   logic        stall_if1, stall_if2;
   logic [31:0] inst;

   assign stall_if1 = stall[STALL_IF1];
   assign stall_if2 = stall[STALL_IF2];

   // Later stall bits belong to downstream stages; monotonicity means IF only
   // needs its own two.
   logic unused_stall;
   assign unused_stall = ^stall[STALL_WD-1:STALL_ID];

   // ---------------- IF1: PC register ----------------
   always_comb begin
      if1_pc_d    = if1_pc_q;
      if1_valid_d = if1_valid_q;
      if (br_e) begin
         // Redirect is taken even when frozen so the target is never lost.
         if1_pc_d = align_word(br_addr);
      end else if (!stall_if1) begin
         if1_pc_d = if1_pc_q + 32'd4;
      end
   end

   // ---------------- IF2: in-flight instruction ----------------
   always_comb begin
      if2_pc_d    = if2_pc_q;
      if2_valid_d = if2_valid_q;
      if (br_e) begin
         if2_valid_d = 1'b0;
      end else if (stall_if1 && !stall_if2) begin
         // IF1 frozen but IF2 free: IF2 drains and a bubble follows.
         if2_valid_d = 1'b0;
      end else if (!stall_if2) begin
         if2_pc_d    = if1_pc_q;
         if2_valid_d = if1_valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if1_pc_q    <= RESET_PC;
         if1_valid_q <= 1'b1;
         if2_pc_q    <= '0;
         if2_valid_q <= 1'b0;
      end else begin
         if1_pc_q    <= if1_pc_d;
         if1_valid_q <= if1_valid_d;
         if2_pc_q    <= if2_pc_d;
         if2_valid_q <= if2_valid_d;
      end
   end

   // A read is issued only when IF2 will actually accept its data next cycle;
   // during a redirect the current PC is already wrong-path.
   assign imem_addr = if1_pc_q;
   assign imem_en   = rst_n & if1_valid_q & ~stall_if2 & ~br_e;

   if_stage_inst_hold_buf u_hold_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_i     (stall_if2),
      .if2_valid_i (if2_valid_q),
      .br_e_i      (br_e),
      .rdata_i     (imem_rdata),
      .inst_o      (inst)
   );

   // Gated by rst_n so the bus is a bubble for the whole reset window, not
   // just after the first reset edge.
   assign if22id_bus = (rst_n && if2_valid_q) ? IF22ID_WD'({if2_pc_q, inst})
                                               : IF22ID_WD'(IF22ID_BUBBLE);

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage with a registered-read SRAM model. The SRAM
// returns addr ^ A5A5A5A5 after an enabled read and DEADBEEF otherwise, so a
// stale or unheld instruction is visible on the bus.
// -----------------------------------------------------------------------------
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic [5:0]  stall;
   logic        br_e;
   logic [31:0] br_addr;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [63:0] if22id_bus;

   int n_checks;
   int n_errors;

   if_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .br_e       (br_e),
      .br_addr    (br_addr),
      .imem_en    (imem_en),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .if22id_bus (if22id_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      imem_rdata <= imem_en ? (imem_addr ^ 32'hA5A5_A5A5) : 32'hDEAD_BEEF;
   end

   function automatic logic [63:0] exp_bus(input logic [31:0] pc);
      return {pc, pc ^ 32'hA5A5_A5A5};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs on the falling edge, then let outputs settle.
   task automatic cyc(input logic r, input logic [5:0] s, input logic b, input logic [31:0] ba);
      @(negedge clk);
      rst_n   = r;
      stall   = s;
      br_e    = b;
      br_addr = ba;
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0; stall = '0; br_e = 1'b0; br_addr = '0;

      cyc(1'b0, 6'd0, 1'b0, 32'h0);
      cyc(1'b0, 6'd0, 1'b0, 32'h0);
      check("rst_en",  {63'd0, imem_en}, 64'd0);
      check("rst_bus", if22id_bus, 64'd0);

      // Free run from reset.
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("c0_addr", {32'd0, imem_addr}, {32'd0, 32'h8000_0000});
      check("c0_en",   {63'd0, imem_en}, 64'd1);
      check("c0_bus",  if22id_bus, 64'd0);
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("c1_bus",  if22id_bus, exp_bus(32'h8000_0000));

      // Full stall for three cycles while IF2 holds 80000004.
      cyc(1'b1, 6'b000111, 1'b0, 32'h0);
      check("st0_bus", if22id_bus, exp_bus(32'h8000_0004));
      check("st0_en",  {63'd0, imem_en}, 64'd0);
      cyc(1'b1, 6'b000111, 1'b0, 32'h0);
      check("st1_bus", if22id_bus, exp_bus(32'h8000_0004));
      cyc(1'b1, 6'b000111, 1'b0, 32'h0);
      check("st2_bus", if22id_bus, exp_bus(32'h8000_0004));
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("rel_bus",  if22id_bus, exp_bus(32'h8000_0004));
      check("rel_addr", {32'd0, imem_addr}, {32'd0, 32'h8000_0008});
      check("rel_en",   {63'd0, imem_en}, 64'd1);

      // IF1-only stall: one bubble, no skipped PC.
      cyc(1'b1, 6'b000001, 1'b0, 32'h0);
      check("s1_bus",  if22id_bus, exp_bus(32'h8000_0008));
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("bub_bus", if22id_bus, 64'd0);
      check("bub_addr", {32'd0, imem_addr}, {32'd0, 32'h8000_000C});
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("nb_bus",  if22id_bus, exp_bus(32'h8000_000C));

      // Branch during full stall; unaligned target.
      cyc(1'b1, 6'b000111, 1'b1, 32'h8000_1003);
      check("br_en",   {63'd0, imem_en}, 64'd0);
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("br_bus",  if22id_bus, 64'd0);
      check("br_addr", {32'd0, imem_addr}, {32'd0, 32'h8000_1000});
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("bt0_bus", if22id_bus, exp_bus(32'h8000_1000));

      // PC wrap.
      cyc(1'b1, 6'd0, 1'b1, 32'hFFFF_FFFC);
      check("bt1_bus", if22id_bus, exp_bus(32'h8000_1004));
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("wr_bus",  if22id_bus, 64'd0);
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("wr0_bus", if22id_bus, exp_bus(32'hFFFF_FFFC));
      check("wr_addr", {32'd0, imem_addr}, 64'd0);
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("wr1_bus", if22id_bus, exp_bus(32'h0000_0000));

      // Back-to-back branches: last target wins.
      cyc(1'b1, 6'd0, 1'b1, 32'h8000_2000);
      cyc(1'b1, 6'd0, 1'b1, 32'h8000_3004);
      check("bb_bus0", if22id_bus, 64'd0);
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("bb_bus1", if22id_bus, 64'd0);
      check("bb_addr", {32'd0, imem_addr}, {32'd0, 32'h8000_3004});
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("bb_bus2", if22id_bus, exp_bus(32'h8000_3004));

      // Reset while the hold buffer is full.
      cyc(1'b1, 6'b000111, 1'b0, 32'h0);
      check("hr_bus0", if22id_bus, exp_bus(32'h8000_3008));
      cyc(1'b1, 6'b000111, 1'b0, 32'h0);
      check("hr_bus1", if22id_bus, exp_bus(32'h8000_3008));
      cyc(1'b0, 6'b000111, 1'b0, 32'h0);
      check("hr_rbus", if22id_bus, 64'd0);
      check("hr_ren",  {63'd0, imem_en}, 64'd0);
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("hr_bus2", if22id_bus, 64'd0);
      check("hr_addr", {32'd0, imem_addr}, {32'd0, 32'h8000_0000});
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("hr_bus3", if22id_bus, exp_bus(32'h8000_0000));
      cyc(1'b1, 6'd0, 1'b0, 32'h0);
      check("hr_bus4", if22id_bus, exp_bus(32'h8000_0004));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
